fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 29 ++
 rtl/fetch_ctrl_sat_counter.sv | 23 ++
 rtl/fetch_ctrl.sv | 133 +++++++++++++
 tb/tb_fetch_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared pipeline definitions for the fetch controller: FSM states and
// redirect-source selection.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ID   = 2'd1,
        SRC_EX   = 2'd2
    } redirect_src_e;

    localparam int PC_W = 32;

    // EX resolves older instructions than ID, so it always wins.
    function automatic redirect_src_e redirect_src(input logic ex_redirect, input logic id_jump);
        if (ex_redirect) begin
            return SRC_EX;
        end else if (id_jump) begin
            return SRC_ID;
        end
        return SRC_NONE;
    endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter used for the stall-cycle performance statistic.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (en && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: steers the PC and IF/ID, ID/EX pipeline registers around
// memory waits, redirects, load-use hazards and halt.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             imem_ready,
    input  logic             load_use_hazard,
    input  logic             ex_redirect,
    input  logic [31:0]      ex_target,
    input  logic             id_jump,
    input  logic [31:0]      id_target,
    input  logic             halt_req,
    output logic             pc_stall,
    output logic             pc_jump,
    output logic [31:0]      pc_jmp_tar,
    output logic             imem_req,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    fetch_state_e  state_q, state_d;
    logic          pend_valid_q, pend_valid_d;
    logic [31:0]   pend_tar_q, pend_tar_d;
    redirect_src_e src;
    logic [31:0]   src_tar;
    logic          ready_path;

    assign src     = redirect_src(ex_redirect, id_jump);
    assign src_tar = (src == SRC_EX) ? ex_target : id_target;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            pend_valid_q <= 1'b0;
            pend_tar_q   <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_tar_q   <= pend_tar_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_tar_d   = pend_tar_q;
        pc_stall     = 1'b0;
        pc_jump      = 1'b0;
        pc_jmp_tar   = '0;
        imem_req     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        halted       = 1'b0;
        ready_path   = 1'b0;

        case (state_q)
            ST_RUN, ST_WAIT: begin
                imem_req = 1'b1;
                if (!imem_ready) begin
                    // Fetch outstanding: hold PC, remember the newest redirect.
                    pc_stall    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = ex_redirect;
                    state_d     = ST_WAIT;
                    if (src != SRC_NONE) begin
                        pend_valid_d = 1'b1;
                        pend_tar_d   = src_tar;
                    end
                end else if (state_q == ST_WAIT) begin
                    pend_valid_d = 1'b0;
                    state_d      = ST_RUN;
                    if ((src == SRC_NONE) && pend_valid_q) begin
                        pc_jump     = 1'b1;
                        pc_jmp_tar  = pend_tar_q;
                        if_id_flush = 1'b1;
                    end else begin
                        ready_path = 1'b1;
                    end
                end else begin
                    ready_path = 1'b1;
                end
            end
            ST_HALT: begin
                pc_stall    = 1'b1;
                if_id_flush = 1'b1;
                halted      = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (ready_path) begin
            state_d = ST_RUN;
            if (src == SRC_EX) begin
                pc_jump     = 1'b1;
                pc_jmp_tar  = ex_target;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (src == SRC_ID) begin
                pc_jump     = 1'b1;
                pc_jmp_tar  = id_target;
                if_id_flush = 1'b1;
            end else if (load_use_hazard) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end else if (halt_req) begin
                pc_stall    = 1'b1;
                if_id_flush = 1'b1;
                state_d     = ST_HALT;
            end
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (pc_stall && (state_q != ST_HALT)),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl; a second instance with a 4-bit
// counter exercises saturation.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        imem_ready;
    logic        load_use_hazard;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        id_jump;
    logic [31:0] id_target;
    logic        halt_req;

    logic        pc_stall, pc_jump, imem_req, if_id_stall, if_id_flush, id_ex_flush, halted;
    logic [31:0] pc_jmp_tar;
    logic [15:0] stall_cycles;

    logic        pc_stall4, pc_jump4, imem_req4, if_id_stall4, if_id_flush4, id_ex_flush4, halted4;
    logic [31:0] pc_jmp_tar4;
    logic [3:0]  stall_cycles4;

    int checks;
    int errors;

    fetch_ctrl dut (
        .clk(clk), .reset(reset), .imem_ready(imem_ready), .load_use_hazard(load_use_hazard),
        .ex_redirect(ex_redirect), .ex_target(ex_target), .id_jump(id_jump), .id_target(id_target),
        .halt_req(halt_req), .pc_stall(pc_stall), .pc_jump(pc_jump), .pc_jmp_tar(pc_jmp_tar),
        .imem_req(imem_req), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .halted(halted), .stall_cycles(stall_cycles)
    );

    fetch_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .imem_ready(imem_ready), .load_use_hazard(load_use_hazard),
        .ex_redirect(ex_redirect), .ex_target(ex_target), .id_jump(id_jump), .id_target(id_target),
        .halt_req(halt_req), .pc_stall(pc_stall4), .pc_jump(pc_jump4), .pc_jmp_tar(pc_jmp_tar4),
        .imem_req(imem_req4), .if_id_stall(if_id_stall4), .if_id_flush(if_id_flush4),
        .id_ex_flush(id_ex_flush4), .halted(halted4), .stall_cycles(stall_cycles4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic applyStimulus(input logic rdy, input logic lu, input logic ex, input logic [31:0] ext,
                                 input logic id, input logic [31:0] idt, input logic hlt);
        imem_ready      = rdy;
        load_use_hazard = lu;
        ex_redirect     = ex;
        ex_target       = ext;
        id_jump         = id;
        id_target       = idt;
        halt_req        = hlt;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        reset = 1'b1;
        nextCycle();
        nextCycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks += 6;
        if (pc_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_pc_stall got %b exp 0", pc_stall); end
        if (pc_jump !== 1'b0) begin errors++; $display("[TB] FAIL reset_pc_jump got %b exp 0", pc_jump); end
        if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL reset_imem_req got %b exp 1", imem_req); end
        if (stall_cycles !== 16'd0) begin errors++; $display("[TB] FAIL reset_stall_cycles got %0d exp 0", stall_cycles); end
        if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted got %b exp 0", halted); end
        if (pc_jmp_tar !== 32'h0) begin errors++; $display("[TB] FAIL reset_tar got %h exp 0", pc_jmp_tar); end
        nextCycle();
    endtask

    task automatic test_redirect_priority();
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
        checks += 5;
        if (pc_jump !== 1'b1) begin errors++; $display("[TB] FAIL ex_id_pc_jump got %b exp 1", pc_jump); end
        if (pc_jmp_tar !== 32'h100) begin errors++; $display("[TB] FAIL ex_id_tar got %h exp 100", pc_jmp_tar); end
        if (if_id_flush !== 1'b1) begin errors++; $display("[TB] FAIL ex_id_if_flush got %b exp 1", if_id_flush); end
        if (id_ex_flush !== 1'b1) begin errors++; $display("[TB] FAIL ex_id_ex_flush got %b exp 1", id_ex_flush); end
        if (pc_stall !== 1'b0) begin errors++; $display("[TB] FAIL ex_id_pc_stall got %b exp 0", pc_stall); end
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
        checks += 4;
        if (pc_jmp_tar !== 32'h200) begin errors++; $display("[TB] FAIL id_tar got %h exp 200", pc_jmp_tar); end
        if (id_ex_flush !== 1'b0) begin errors++; $display("[TB] FAIL id_ex_flush got %b exp 0", id_ex_flush); end
        if (pc_stall !== 1'b0) begin errors++; $display("[TB] FAIL id_over_lu_stall got %b exp 0", pc_stall); end
        if (if_id_stall !== 1'b0) begin errors++; $display("[TB] FAIL id_over_lu_ifid_stall got %b exp 0", if_id_stall); end
        nextCycle();
    endtask

    task automatic test_load_use();
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks += 4;
        if (pc_stall !== 1'b1) begin errors++; $display("[TB] FAIL lu_pc_stall got %b exp 1", pc_stall); end
        if (if_id_stall !== 1'b1) begin errors++; $display("[TB] FAIL lu_ifid_stall got %b exp 1", if_id_stall); end
        if (id_ex_flush !== 1'b1) begin errors++; $display("[TB] FAIL lu_idex_flush got %b exp 1", id_ex_flush); end
        if (pc_jump !== 1'b0) begin errors++; $display("[TB] FAIL lu_pc_jump got %b exp 0", pc_jump); end
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks += 2;
        if (stall_cycles !== 16'd1) begin errors++; $display("[TB] FAIL lu_stall_cycles got %0d exp 1", stall_cycles); end
        if (pc_stall !== 1'b0) begin errors++; $display("[TB] FAIL lu_release got %b exp 0", pc_stall); end
        nextCycle();
    endtask

    task automatic test_wait_redirect();
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0);
        checks += 4;
        if (pc_stall !== 1'b1) begin errors++; $display("[TB] FAIL wait1_pc_stall got %b exp 1", pc_stall); end
        if (if_id_flush !== 1'b1) begin errors++; $display("[TB] FAIL wait1_if_flush got %b exp 1", if_id_flush); end
        if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL wait1_imem_req got %b exp 1", imem_req); end
        if (pc_jump !== 1'b0) begin errors++; $display("[TB] FAIL wait1_pc_jump got %b exp 0", pc_jump); end
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
        checks += 3;
        if (pc_stall !== 1'b1) begin errors++; $display("[TB] FAIL wait2_pc_stall got %b exp 1", pc_stall); end
        if (id_ex_flush !== 1'b1) begin errors++; $display("[TB] FAIL wait2_idex_flush got %b exp 1", id_ex_flush); end
        if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL wait2_imem_req got %b exp 1", imem_req); end
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks += 2;
        if (pc_stall !== 1'b1) begin errors++; $display("[TB] FAIL wait3_pc_stall got %b exp 1", pc_stall); end
        if (id_ex_flush !== 1'b0) begin errors++; $display("[TB] FAIL wait3_idex_flush got %b exp 0", id_ex_flush); end
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks += 4;
        if (pc_jump !== 1'b1) begin errors++; $display("[TB] FAIL wait_exit_jump got %b exp 1", pc_jump); end
        if (pc_jmp_tar !== 32'h80) begin errors++; $display("[TB] FAIL wait_exit_tar got %h exp 80", pc_jmp_tar); end
        if (pc_stall !== 1'b0) begin errors++; $display("[TB] FAIL wait_exit_stall got %b exp 0", pc_stall); end
        if (stall_cycles !== 16'd3) begin errors++; $display("[TB] FAIL wait_stall_cycles got %0d exp 3", stall_cycles); end
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks += 2;
        if (pc_jump !== 1'b0) begin errors++; $display("[TB] FAIL pend_cleared_jump got %b exp 0", pc_jump); end
        if (stall_cycles !== 16'd3) begin errors++; $display("[TB] FAIL wait_stall_final got %0d exp 3", stall_cycles); end
        nextCycle();
    endtask

    task automatic test_wait_live_override();
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hC0, 1'b0, 32'h0, 1'b0);
        checks += 3;
        if (pc_jump !== 1'b1) begin errors++; $display("[TB] FAIL live_jump got %b exp 1", pc_jump); end
        if (pc_jmp_tar !== 32'hC0) begin errors++; $display("[TB] FAIL live_tar got %h exp c0", pc_jmp_tar); end
        if (id_ex_flush !== 1'b1) begin errors++; $display("[TB] FAIL live_idex_flush got %b exp 1", id_ex_flush); end
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks += 1;
        if (pc_jump !== 1'b0) begin errors++; $display("[TB] FAIL live_after_jump got %b exp 0", pc_jump); end
        nextCycle();
    endtask

    task automatic test_reset_mid_wait();
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
        nextCycle();
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks += 4;
        if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL rmw_imem_req got %b exp 1", imem_req); end
        if (pc_jump !== 1'b0) begin errors++; $display("[TB] FAIL rmw_pc_jump got %b exp 0", pc_jump); end
        if (pc_stall !== 1'b0) begin errors++; $display("[TB] FAIL rmw_pc_stall got %b exp 0", pc_stall); end
        if (stall_cycles !== 16'd0) begin errors++; $display("[TB] FAIL rmw_stall_cycles got %0d exp 0", stall_cycles); end
        nextCycle();
    endtask

    task automatic test_halt();
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checks += 3;
        if (pc_stall !== 1'b1) begin errors++; $display("[TB] FAIL halt_req_stall got %b exp 1", pc_stall); end
        if (if_id_flush !== 1'b1) begin errors++; $display("[TB] FAIL halt_req_flush got %b exp 1", if_id_flush); end
        if (halted !== 1'b0) begin errors++; $display("[TB] FAIL halt_req_halted got %b exp 0", halted); end
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0);
        checks += 5;
        if (halted !== 1'b1) begin errors++; $display("[TB] FAIL halted got %b exp 1", halted); end
        if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL halt_imem_req got %b exp 0", imem_req); end
        if (pc_jump !== 1'b0) begin errors++; $display("[TB] FAIL halt_ignore_jump got %b exp 0", pc_jump); end
        if (pc_jmp_tar !== 32'h0) begin errors++; $display("[TB] FAIL halt_ignore_tar got %h exp 0", pc_jmp_tar); end
        if (pc_stall !== 1'b1) begin errors++; $display("[TB] FAIL halt_pc_stall got %b exp 1", pc_stall); end
        nextCycle();
        nextCycle();
        nextCycle();
        checks += 2;
        if (halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_sticky got %b exp 1", halted); end
        if (stall_cycles !== 16'd1) begin errors++; $display("[TB] FAIL halt_stall_cycles got %0d exp 1", stall_cycles); end
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks += 2;
        if (halted !== 1'b0) begin errors++; $display("[TB] FAIL halt_reset_halted got %b exp 0", halted); end
        if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL halt_reset_imem_req got %b exp 1", imem_req); end
        nextCycle();
    endtask

    task automatic test_saturation();
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            nextCycle();
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks += 2;
        if (stall_cycles4 !== 4'hF) begin errors++; $display("[TB] FAIL sat4_count got %h exp f", stall_cycles4); end
        if (stall_cycles !== 16'd20) begin errors++; $display("[TB] FAIL sat16_count got %0d exp 20", stall_cycles); end
        nextCycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        test_reset();
        test_redirect_priority();
        test_load_use();
        test_wait_redirect();
        test_wait_live_override();
        test_reset_mid_wait();
        test_halt();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
